// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns the program counter and steps each instruction
// through fetch, decode, execute, optional data-memory access and writeback.
module instr_sequencer #(
   parameter int unsigned     PC_W       = 10,
   parameter int unsigned     CNT_W      = 16,
   parameter logic [PC_W-1:0] START_ADDR = '0
) (
   input  logic              CLK,
   input  logic              reset_n,
   input  logic              start,
   input  logic              imem_ready,
   input  logic              halt,
   input  logic              branch,
   input  logic              branch_taken,
   input  logic [PC_W-1:0]   branch_target,
   input  logic              mem_access,
   input  logic              mem_ready,
   output logic [PC_W-1:0]   pc,
   output logic              imem_req,
   output logic              ir_load,
   output logic              exec_en,
   output logic              mem_req,
   output logic              reg_wr_en,
   output logic              done,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  instr_count
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALTED = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state;
   state_t state_n;
   logic   go;
   logic   retire;
   logic   active;

   assign active = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
                   (state == MEM)   || (state == WB);

   // State register
   always_ff @(posedge CLK) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   // Next-state logic plus the start and retire events that steer pc and counters
   always_comb begin
      state_n = state;
      go      = 1'b0;
      retire  = 1'b0;
      unique case (state)
         IDLE, HALTED: begin
            if (start) begin
               state_n = FETCH;
               go      = 1'b1;
            end
         end
         FETCH:  if (imem_ready) state_n = DECODE;
         DECODE: begin
            if (halt) begin
               state_n = HALTED;
               retire  = 1'b1;
            end else begin
               state_n = EXEC;
            end
         end
         EXEC:   state_n = mem_access ? MEM : WB;
         MEM:    if (mem_ready) state_n = WB;
         WB: begin
            state_n = FETCH;
            retire  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   // Strobes are registered decodes of the state being entered
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         imem_req  <= 1'b0;
         ir_load   <= 1'b0;
         exec_en   <= 1'b0;
         mem_req   <= 1'b0;
         reg_wr_en <= 1'b0;
         done      <= 1'b0;
      end else begin
         imem_req  <= (state_n == FETCH);
         ir_load   <= (state_n == DECODE);
         exec_en   <= (state_n == EXEC);
         mem_req   <= (state_n == MEM);
         reg_wr_en <= (state_n == WB);
         done      <= (state_n == HALTED);
      end
   end

   // Program counter and saturating run counters
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         pc          <= START_ADDR;
         cycle_count <= '0;
         instr_count <= '0;
      end else if (go) begin
         pc          <= START_ADDR;
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         if (state == WB)
            pc <= (branch && branch_taken) ? branch_target : pc + PC_W'(1);
         if (active && (cycle_count != CNT_MAX))
            cycle_count <= cycle_count + CNT_W'(1);
         if (retire && (instr_count != CNT_MAX))
            instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule
